mem_arbiter: RTL
================

# mem_arbiter

Shares the single core-side memory port between three requesters inside the MMU: instruction read, data read and data write. It captures one pending request per requester, grants one at a time by fixed priority with an optional starvation guard, and runs a single outstanding transaction on the downstream port. It returns read data with the echoed address, or a write-done pulse, to the requester that owns the transaction. It also drives MEM_WAIT to stall the core pipeline.

## Interface
Parameters:
- STARVE_LIMIT, 4: consecutive data grants allowed while an instruction read is pending (1..15).

Ports:
- CLK  in  1  system clock; all state changes on its rising edge.
- RST  in  1  asynchronous, active-low reset.
- INST_RDEN  in  1  one-cycle instruction read request.
- INST_RIADDR  in  32  instruction read address.
- INST_RVALID  out  1  one-cycle read-return strobe.
- INST_ROADDR  out  32  address of returned instruction.
- INST_RDATA  out  32  returned instruction.
- DATA_RDEN  in  1  one-cycle data read request.
- DATA_RIADDR  in  32  data read address.
- DATA_RVALID  out  1  one-cycle read-return strobe.
- DATA_ROADDR  out  32  address of returned data.
- DATA_RDATA  out  32  returned data word.
- DATA_WREN  in  1  one-cycle data write request.
- DATA_WADDR  in  32  write address.
- DATA_WSTRB  in  4  write byte strobes.
- DATA_WDATA  in  32  write data.
- DATA_WDONE  out  1  one-cycle write-complete pulse.
- MEM_WAIT  out  1  high while any request is pending or in flight.
- MEM_REQ  out  1  downstream request valid.
- MEM_WE  out  1  1 = write, 0 = read.
- MEM_ADDR  out  32  downstream address.
- MEM_STRB  out  4  downstream strobes (4'hF for reads).
- MEM_WDATA  out  32  downstream write data.
- MEM_ACK  in  1  downstream accepts the request when MEM_REQ is high.
- MEM_RVALID  in  1  read data valid.
- MEM_RDATA  in  32  read data.
- MEM_BVALID  in  1  write response.

## Operation
- Pending slots:
  - Each requester has one slot: a valid flag plus the captured address, and for the write slot also strobes and data.
  - A request pulse sets the slot.
  - A read pulse that arrives while its slot is pending but not yet granted overwrites the address, so the latest request wins.
  - DATA_WREN while the write slot is pending is ignored. The core must not issue it; MEM_WAIT is already high.
  - A slot clears on grant. A new pulse arriving while the same requester is in flight fills the slot again.
- Priority: write > data read > instruction read. The starvation guard (see Configuration) can override this.
- FSM states and transitions:
  - IDLE: if any slot is valid, grant the winner, load the MEM_* registers and go to ISSUE.
  - ISSUE: MEM_REQ=1. When MEM_ACK=1, go to WAIT_R (read) or WAIT_B (write).
  - WAIT_R: on MEM_RVALID, register MEM_RDATA and the granted address onto the owner's R* outputs, pulse the owner's RVALID, and go to IDLE.
  - WAIT_B: on MEM_BVALID, pulse DATA_WDONE and go to IDLE.
- MEM_RVALID or MEM_BVALID arriving outside its matching wait state is ignored.
- MEM_WAIT = any slot valid OR state != IDLE. It is registered.

## Timing
- Reset values: all outputs are 0, FSM is in IDLE, all slots are empty, the starvation counter is 0. RST low mid-transaction aborts immediately with no completion pulse.
- A request pulse sampled at edge k sets its slot and MEM_WAIT after edge k. The FSM grants at edge k+1, so MEM_REQ is high after k+1.
- MEM_REQ, MEM_WE, MEM_ADDR, MEM_STRB and MEM_WDATA stay stable from ISSUE until the edge that samples MEM_ACK=1.
- Minimum read latency, with MEM_ACK at k+2 and MEM_RVALID at k+3: RVALID is high for exactly the one cycle after k+3.
- Back-to-back: arbitration happens in the IDLE cycle that follows completion. There is one idle cycle between transactions.
- RVALID, WDONE and the R* data are registered. R* data holds until the next return to the same requester.

## Configuration
- SASANQUA_ARB_STARVE_GUARD_EN defined:
  - A 4-bit counter increments on each data grant (read or write) made while the instruction slot is valid.
  - When the counter equals STARVE_LIMIT, the next grant goes to the instruction read.
  - The counter clears on any instruction grant, and also whenever the instruction slot is empty.
- Undefined: strict priority, and the counter logic is absent.

## Test plan
- Single fetch:
  - Stimulus: INST_RDEN with addr 0x0000_0100; memory acks immediately and returns 0x0000_0013 one cycle after ack.
  - Required: INST_RVALID pulses 3 cycles after RDEN, with ROADDR=0x100 and RDATA=0x13. MEM_WAIT falls the cycle after.
- Simultaneous requests:
  - Stimulus: INST_RDEN, DATA_RDEN and DATA_WREN in the same cycle.
  - Required: grant order is write, then data read, then instruction read, each with MEM_REQ held until MEM_ACK. Exactly one DATA_WDONE, DATA_RVALID and INST_RVALID pulse occur.
- Overwrite:
  - Stimulus: INST_RDEN at 0x200 during a data read in flight, then INST_RDEN at 0x300 before the grant.
  - Required: only 0x300 is fetched; exactly one INST_RVALID pulse.
- Starvation (macro on, STARVE_LIMIT=4):
  - Stimulus: an instruction read is pending while data reads are continuously re-requested.
  - Required: the fifth grant is the instruction read. With the macro off, the instruction read is never granted until data requests stop.
- Back-pressure and reset:
  - Stimulus: hold MEM_ACK low for 10 cycles, checking that MEM_ADDR and MEM_WE stay stable. Then assert RST during WAIT_R.
  - Required: all outputs are 0 and no RVALID is produced; a late MEM_RVALID after release is ignored.

Source files
------------

// File: rtl/mem_arbiter.sv
// mem_arbiter
//   Shares one downstream memory port between the instruction-read,
//   data-read and data-write requesters. Each requester owns a single
//   pending slot; an FSM grants one slot at a time (write > data read >
//   instruction read) and runs one outstanding transaction downstream.
//   Read data returns with its echoed address to the owning requester;
//   writes complete with a DATA_WDONE pulse. MEM_WAIT stalls the core.
//
// Optional feature (macro SASANQUA_ARB_STARVE_GUARD_EN):
//   When defined, a 4-bit counter tracks data grants made while an
//   instruction read waits. Once it reaches STARVE_LIMIT, the next grant
//   goes to the instruction read. When undefined, priority is strict.
//
// Ports:
//   CLK, RST                  clock, asynchronous active-low reset
//   INST_RDEN/RIADDR          instruction read request
//   INST_RVALID/ROADDR/RDATA  instruction read return
//   DATA_RDEN/RIADDR          data read request
//   DATA_RVALID/ROADDR/RDATA  data read return
//   DATA_WREN/WADDR/WSTRB/WDATA  data write request
//   DATA_WDONE                write-complete pulse
//   MEM_WAIT                  pipeline stall
//   MEM_REQ/WE/ADDR/STRB/WDATA   downstream request
//   MEM_ACK                   downstream request accepted
//   MEM_RVALID/RDATA          downstream read response
//   MEM_BVALID                downstream write response

module mem_arbiter #(
    parameter int STARVE_LIMIT = 4
) (
    input  logic        CLK,
    input  logic        RST,
    input  logic        INST_RDEN,
    input  logic [31:0] INST_RIADDR,
    output logic        INST_RVALID,
    output logic [31:0] INST_ROADDR,
    output logic [31:0] INST_RDATA,
    input  logic        DATA_RDEN,
    input  logic [31:0] DATA_RIADDR,
    output logic        DATA_RVALID,
    output logic [31:0] DATA_ROADDR,
    output logic [31:0] DATA_RDATA,
    input  logic        DATA_WREN,
    input  logic [31:0] DATA_WADDR,
    input  logic [3:0]  DATA_WSTRB,
    input  logic [31:0] DATA_WDATA,
    output logic        DATA_WDONE,
    output logic        MEM_WAIT,
    output logic        MEM_REQ,
    output logic        MEM_WE,
    output logic [31:0] MEM_ADDR,
    output logic [3:0]  MEM_STRB,
    output logic [31:0] MEM_WDATA,
    input  logic        MEM_ACK,
    input  logic        MEM_RVALID,
    input  logic [31:0] MEM_RDATA,
    input  logic        MEM_BVALID
);

    localparam logic [1:0] S_IDLE   = 2'd0;
    localparam logic [1:0] S_ISSUE  = 2'd1;
    localparam logic [1:0] S_WAIT_R = 2'd2;
    localparam logic [1:0] S_WAIT_B = 2'd3;

    logic [1:0]  state, state_nxt;
    logic        own_inst;           // read owner: 1 = instruction, 0 = data

    logic        i_vld, d_vld, w_vld;
    logic [31:0] i_addr, d_addr, w_addr, w_data;
    logic [3:0]  w_strb;

    logic        gnt_i, gnt_d, gnt_w, gnt_any;
    logic        i_vld_nxt, d_vld_nxt, w_vld_nxt, w_load;

`ifdef SASANQUA_ARB_STARVE_GUARD_EN
    localparam logic [3:0] STARVE_LIM4 = 4'(STARVE_LIMIT);
    logic [3:0] starve_cnt;
    logic       starve_hit;

    assign starve_hit = i_vld && (starve_cnt == STARVE_LIM4);

    // Counts data grants made over a waiting fetch; any fetch grant or an
    // empty instruction slot restarts the count.
    always_ff @(posedge CLK or negedge RST) begin
        if (!RST)
            starve_cnt <= 4'd0;
        else if (gnt_i || !i_vld)
            starve_cnt <= 4'd0;
        else if (gnt_d || gnt_w)
            starve_cnt <= starve_cnt + 4'd1;
    end
`else
    // The limit only matters when the starvation guard is built in.
    logic [31:0] unused_starve_limit;
    assign unused_starve_limit = 32'(STARVE_LIMIT);
`endif

    // Grant decision is only taken in IDLE.
    always_comb begin
        gnt_i = 1'b0;
        gnt_d = 1'b0;
        gnt_w = 1'b0;
        if (state == S_IDLE) begin
`ifdef SASANQUA_ARB_STARVE_GUARD_EN
            if (starve_hit)  gnt_i = 1'b1;
            else if (w_vld)  gnt_w = 1'b1;
            else if (d_vld)  gnt_d = 1'b1;
            else if (i_vld)  gnt_i = 1'b1;
`else
            if (w_vld)       gnt_w = 1'b1;
            else if (d_vld)  gnt_d = 1'b1;
            else if (i_vld)  gnt_i = 1'b1;
`endif
        end
    end

    assign gnt_any = gnt_i | gnt_d | gnt_w;

    // A fresh pulse on the grant edge refills the slot; a second write
    // while the write slot is still pending is dropped.
    assign w_load    = DATA_WREN & (~w_vld | gnt_w);
    assign i_vld_nxt = INST_RDEN | (i_vld & ~gnt_i);
    assign d_vld_nxt = DATA_RDEN | (d_vld & ~gnt_d);
    assign w_vld_nxt = w_load | (w_vld & ~gnt_w);

    always_comb begin
        state_nxt = state;
        case (state)
            S_IDLE:   if (gnt_any)    state_nxt = S_ISSUE;
            S_ISSUE:  if (MEM_ACK)    state_nxt = MEM_WE ? S_WAIT_B : S_WAIT_R;
            S_WAIT_R: if (MEM_RVALID) state_nxt = S_IDLE;
            S_WAIT_B: if (MEM_BVALID) state_nxt = S_IDLE;
            default:                  state_nxt = S_IDLE;
        endcase
    end

    // Slot valid flags
    always_ff @(posedge CLK or negedge RST) begin
        if (!RST) begin
            i_vld <= 1'b0;
            d_vld <= 1'b0;
            w_vld <= 1'b0;
        end else begin
            i_vld <= i_vld_nxt;
            d_vld <= d_vld_nxt;
            w_vld <= w_vld_nxt;
        end
    end

    // Slot payloads; a read pulse overwrites a pending address so the
    // latest request wins.
    always_ff @(posedge CLK) begin
        if (INST_RDEN) i_addr <= INST_RIADDR;
        if (DATA_RDEN) d_addr <= DATA_RIADDR;
        if (w_load) begin
            w_addr <= DATA_WADDR;
            w_strb <= DATA_WSTRB;
            w_data <= DATA_WDATA;
        end
    end

    // FSM, downstream request and return registers
    always_ff @(posedge CLK or negedge RST) begin
        if (!RST) begin
            state       <= S_IDLE;
            own_inst    <= 1'b0;
            MEM_WAIT    <= 1'b0;
            MEM_REQ     <= 1'b0;
            MEM_WE      <= 1'b0;
            MEM_ADDR    <= 32'd0;
            MEM_STRB    <= 4'd0;
            MEM_WDATA   <= 32'd0;
            INST_RVALID <= 1'b0;
            INST_ROADDR <= 32'd0;
            INST_RDATA  <= 32'd0;
            DATA_RVALID <= 1'b0;
            DATA_ROADDR <= 32'd0;
            DATA_RDATA  <= 32'd0;
            DATA_WDONE  <= 1'b0;
        end else begin
            state       <= state_nxt;
            // Registered from next-state values so it rises with the slot.
            MEM_WAIT    <= i_vld_nxt | d_vld_nxt | w_vld_nxt | (state_nxt != S_IDLE);
            INST_RVALID <= 1'b0;
            DATA_RVALID <= 1'b0;
            DATA_WDONE  <= 1'b0;
            case (state)
                S_IDLE: begin
                    if (gnt_any) begin
                        MEM_REQ   <= 1'b1;
                        MEM_WE    <= gnt_w;
                        own_inst  <= gnt_i;
                        MEM_ADDR  <= gnt_w ? w_addr : (gnt_d ? d_addr : i_addr);
                        MEM_STRB  <= gnt_w ? w_strb : 4'hF;
                        MEM_WDATA <= gnt_w ? w_data : 32'd0;
                    end
                end
                S_ISSUE: begin
                    if (MEM_ACK) MEM_REQ <= 1'b0;
                end
                S_WAIT_R: begin
                    // MEM_ADDR still holds the granted address here.
                    if (MEM_RVALID) begin
                        if (own_inst) begin
                            INST_RVALID <= 1'b1;
                            INST_ROADDR <= MEM_ADDR;
                            INST_RDATA  <= MEM_RDATA;
                        end else begin
                            DATA_RVALID <= 1'b1;
                            DATA_ROADDR <= MEM_ADDR;
                            DATA_RDATA  <= MEM_RDATA;
                        end
                    end
                end
                S_WAIT_B: begin
                    if (MEM_BVALID) DATA_WDONE <= 1'b1;
                end
                default: ;
            endcase
        end
    end

endmodule
